// File: rtl/vending_input_conditioner.sv
// Synchronises, debounces and edge-detects raw coin/button levels for vending_fsm.
// Issues at most one clean pulse per cycle and flags jammed coin sensors.
module vending_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STUCK_CYCLES    = 200,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_5_raw,
    input  logic       coin_10_raw,
    input  logic       cancel_raw,
    input  logic [2:0] btn_raw,
    output logic       coin_5,
    output logic       coin_10,
    output logic       cancel,
    output logic [1:0] select,
    output logic       coin_jam,
    output logic       btn_conflict
);
    localparam int NCH = 6;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_CYCLES);

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1_q, s2_q;
    logic [NCH-1:0]   deb_q, deb_d, prev_q;
    logic [NCH-1:0]   arm_q, arm_d, rise;
    logic [1:0]       rdy_q;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [CNT_W-1:0] stk_q [2];
    logic [CNT_W-1:0] stk_d [2];
    logic             jam_q, jam_d;
    logic             pcan_q, pcan_d, p10_q, p10_d, p5_q, p5_d;
    logic [1:0]       psel_q, psel_d;
    logic             can_q, can_d, c10_q, c10_d, c5_q, c5_d;
    logic [1:0]       sel_q, sel_d;
    logic             conf_q, conf_d;
    logic [2:0]       brise;
    logic             multi;
    logic [1:0]       new_code;

    assign raw = {btn_raw, cancel_raw, coin_10_raw, coin_5_raw};

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // A channel only arms once its synced level has been seen low after reset,
    // so levels already high at reset release never produce a pulse.
    assign arm_d = arm_q | ({NCH{rdy_q[1]}} & ~s2_q);
    assign rise  = deb_q & ~prev_q & arm_q;
    assign brise = rise[5:3];
    assign multi = (brise[0] & brise[1]) | (brise[0] & brise[2]) |
                   (brise[1] & brise[2]);

    always_comb begin
        new_code = 2'b00;
        if (!multi) begin
            unique case (1'b1)
                brise[2]: new_code = 2'b11;
                brise[1]: new_code = 2'b10;
                brise[0]: new_code = 2'b01;
                default:  new_code = 2'b00;
            endcase
        end
    end

    always_comb begin
        for (int j = 0; j < 2; j++) begin
            stk_d[j] = '0;
            if (deb_q[j]) begin
                stk_d[j] = (stk_q[j] == STUCK_MAX) ? stk_q[j]
                                                   : stk_q[j] + CNT_W'(1);
            end
        end
        jam_d = jam_q | (stk_d[0] == STUCK_MAX) | (stk_d[1] == STUCK_MAX);
    end

    always_comb begin
        can_d  = 1'b0;
        c10_d  = 1'b0;
        c5_d   = 1'b0;
        sel_d  = 2'b00;
        pcan_d = pcan_q;
        p10_d  = p10_q;
        p5_d   = p5_q;
        psel_d = psel_q;
        if (pcan_q) begin
            can_d  = 1'b1;
            pcan_d = 1'b0;
            psel_d = 2'b00;
        end else if (p10_q) begin
            c10_d = 1'b1;
            p10_d = 1'b0;
        end else if (p5_q) begin
            c5_d = 1'b1;
            p5_d = 1'b0;
        end else if (psel_q != 2'b00) begin
            sel_d  = psel_q;
            psel_d = 2'b00;
        end
        if (rise[2])           pcan_d = 1'b1;
        if (rise[1] && !jam_q) p10_d  = 1'b1;
        if (rise[0] && !jam_q) p5_d   = 1'b1;
        if (new_code != 2'b00) psel_d = new_code;
        conf_d = multi;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            deb_q  <= '0;
            prev_q <= '0;
            arm_q  <= '0;
            rdy_q  <= '0;
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            for (int j = 0; j < 2; j++) stk_q[j] <= '0;
            jam_q  <= 1'b0;
            pcan_q <= 1'b0;
            p10_q  <= 1'b0;
            p5_q   <= 1'b0;
            psel_q <= 2'b00;
            can_q  <= 1'b0;
            c10_q  <= 1'b0;
            c5_q   <= 1'b0;
            sel_q  <= 2'b00;
            conf_q <= 1'b0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            deb_q  <= deb_d;
            prev_q <= deb_q;
            arm_q  <= arm_d;
            rdy_q  <= {rdy_q[0], 1'b1};
            for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
            for (int j = 0; j < 2; j++) stk_q[j] <= stk_d[j];
            jam_q  <= jam_d;
            pcan_q <= pcan_d;
            p10_q  <= p10_d;
            p5_q   <= p5_d;
            psel_q <= psel_d;
            can_q  <= can_d;
            c10_q  <= c10_d;
            c5_q   <= c5_d;
            sel_q  <= sel_d;
            conf_q <= conf_d;
        end
    end

    assign coin_5       = c5_q;
    assign coin_10      = c10_q;
    assign cancel       = can_q;
    assign select       = sel_q;
    assign coin_jam     = jam_q;
    assign btn_conflict = conf_q;
endmodule
